// File: rtl/mc_control_fsm_pkg.sv
// Shared types and encodings for the multicycle RISC-V control sequencer.
// Holds the state enum, opcode constants and datapath select encodings.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JALR     = 4'd9,
    S_JAL      = 4'd10,
    S_BRANCH   = 4'd11,
    S_LUI      = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'b00,
    ALUOP_SUB  = 2'b01,
    ALUOP_FUNC = 2'b10
  } alu_op_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // blt/bge look only at the raw sign of rs1-rs2; overflow is not corrected.
  function automatic logic branch_taken(input logic [2:0] func3, input logic zero,
                                        input logic neg);
    logic taken;
    case (func3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = neg;
      3'b101:  taken = ~neg;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU operation decode: maps ALUOp and the instruction fields to ALUControl.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] func3,
  input  logic       func7_5,
  input  logic       op_5,
  output logic [2:0] alu_control
);

  // Fixed add/sub for address and branch steps, func3/func7 decode otherwise
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNC: begin
        case (func3)
          3'b000: begin
            // I-type addi has no sub form, so func7 only matters for R-type
            if (op_5 && func7_5) alu_control = ALU_SUB;
            else                 alu_control = ALU_ADD;
          end
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control sequencer: Moore FSM, branch resolution and immediate
// decode driving the shared-ALU, unified-memory RISC-V datapath.
module mc_control_fsm
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       neg,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] immSrc
);

  state_t  state_r;
  state_t  state_next_s;
  alu_op_t alu_op_s;
  logic    pc_write_s;
  logic    mem_write_s;
  logic    ir_write_s;
  logic    reg_write_s;
  logic    unused_func7_s;

  assign unused_func7_s = ^{func7[6], func7[4:0]};

  // State register with synchronous reset into FETCH
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_FETCH;
    else     state_r <= state_next_s;
  end

  // Next-state and per-state Moore output decode
  always_comb begin
    state_next_s = S_FETCH;
    pc_write_s   = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    AdrSrc       = 1'b0;
    resultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RS2;
    alu_op_s     = ALUOP_ADD;
    case (state_r)
      S_FETCH: begin
        ir_write_s   = 1'b1;
        pc_write_s   = 1'b1;
        ALUSrcB      = SRCB_FOUR;
        resultSrc    = RES_ALU;
        state_next_s = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_next_s = S_MEMADR;
          OP_R:         state_next_s = S_EXECR;
          OP_I:         state_next_s = S_EXECI;
          OP_JAL:       state_next_s = S_JAL;
          OP_JALR:      state_next_s = S_JALR;
          OP_B:         state_next_s = S_BRANCH;
          OP_LUI:       state_next_s = S_LUI;
          default:      state_next_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        if (op == OP_SW) state_next_s = S_MEMWRITE;
        else             state_next_s = S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc       = 1'b1;
        state_next_s = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrc   = RES_MEM;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA      = SRCA_RS1;
        alu_op_s     = ALUOP_FUNC;
        state_next_s = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA      = SRCA_RS1;
        ALUSrcB      = SRCB_IMM;
        alu_op_s     = ALUOP_FUNC;
        state_next_s = S_ALUWB;
      end
      S_ALUWB: reg_write_s = 1'b1;
      S_JALR: begin
        ALUSrcA      = SRCA_RS1;
        ALUSrcB      = SRCB_IMM;
        state_next_s = S_JAL;
      end
      S_JAL: begin
        // PC takes the target latched in ALUOut while OldPC+4 is computed
        pc_write_s   = 1'b1;
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        state_next_s = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        alu_op_s   = ALUOP_SUB;
        pc_write_s = branch_taken(func3, zero, neg);
      end
      S_LUI: begin
        resultSrc   = RES_IMM;
        reg_write_s = 1'b1;
      end
      default: state_next_s = S_FETCH;
    endcase
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    immSrc = IMM_I;
    case (op)
      OP_SW:   immSrc = IMM_S;
      OP_B:    immSrc = IMM_B;
      OP_JAL:  immSrc = IMM_J;
      OP_LUI:  immSrc = IMM_U;
      default: immSrc = IMM_I;
    endcase
  end

  // No architectural write may escape while reset is held
  assign PCWrite  = pc_write_s  & ~rst;
  assign MemWrite = mem_write_s & ~rst;
  assign IRWrite  = ir_write_s  & ~rst;
  assign RegWrite = reg_write_s & ~rst;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op_s),
    .func3       (func3),
    .func7_5     (func7[5]),
    .op_5        (op[5]),
    .alu_control (ALUControl)
  );

endmodule
